// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, forwarding, redirect flush, halt drain
// and saturating stall/flush event counters for a 5-stage RISC-V pipeline.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             halt_req_IF,
    input  logic [4:0]       rs1_Dec,
    input  logic [4:0]       rs2_Dec,
    input  logic             rs1_used_Dec,
    input  logic             rs2_used_Dec,
    input  logic [4:0]       rd_Exec,
    input  logic [4:0]       rd_Mem,
    input  logic [4:0]       rd_WB,
    input  logic             wrEn_Exec,
    input  logic             wrEn_Mem,
    input  logic             wrEn_WB,
    input  logic             is_load_Exec,
    input  logic             is_load_Mem,
    input  logic             npc_control_Mem,
    output logic             stall_IF,
    output logic             stall_Dec,
    output logic             bubble_Exec,
    output logic             flush_IFDec,
    output logic             flush_DecExec,
    output logic             flush_ExecMem,
    output logic [1:0]       fwd_A_sel,
    output logic [1:0]       fwd_B_sel,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hit1, hit2, lu, redir, stall_inc, flush_inc;

    // Load data only becomes forwardable from WB, so loads in Exec or Mem stall.
    assign hit1 = rs1_used_Dec && rs1_Dec != '0 &&
                  ((wrEn_Exec && is_load_Exec && rd_Exec == rs1_Dec) ||
                   (wrEn_Mem && is_load_Mem && rd_Mem == rs1_Dec));
    assign hit2 = rs2_used_Dec && rs2_Dec != '0 &&
                  ((wrEn_Exec && is_load_Exec && rd_Exec == rs2_Dec) ||
                   (wrEn_Mem && is_load_Mem && rd_Mem == rs2_Dec));
    assign lu    = hit1 || hit2;
    assign redir = npc_control_Mem;

    assign stall_inc = rstn && state != HALTED && lu && !redir;
    assign flush_inc = rstn && state != HALTED && redir;

    always_comb begin
        fwd_A_sel     = 2'b00;
        fwd_B_sel     = 2'b00;
        stall_IF      = 1'b0;
        stall_Dec     = 1'b0;
        bubble_Exec   = 1'b0;
        flush_IFDec   = 1'b0;
        flush_DecExec = 1'b0;
        flush_ExecMem = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;
        if (rstn) begin
            fwd_A_sel = (wrEn_Mem && !is_load_Mem && rd_Mem != '0 && rd_Mem == rs1_Dec) ? 2'b01 :
                        (wrEn_WB && rd_WB != '0 && rd_WB == rs1_Dec) ? 2'b10 : 2'b00;
            fwd_B_sel = (wrEn_Mem && !is_load_Mem && rd_Mem != '0 && rd_Mem == rs2_Dec) ? 2'b01 :
                        (wrEn_WB && rd_WB != '0 && rd_WB == rs2_Dec) ? 2'b10 : 2'b00;
            if (state == HALTED) begin
                stall_IF      = 1'b1;
                stall_Dec     = 1'b1;
                flush_IFDec   = 1'b1;
                flush_DecExec = 1'b1;
                flush_ExecMem = 1'b1;
            end else if (redir) begin
                flush_IFDec   = 1'b1;
                flush_DecExec = 1'b1;
                flush_ExecMem = 1'b1;
                state_nxt     = RUN;
                cnt_nxt       = 4'd0;
            end else begin
                stall_Dec   = lu;
                bubble_Exec = lu;
                stall_IF    = lu || state == DRAIN;
                flush_IFDec = state == DRAIN;
                if (state == RUN && halt_req_IF) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 4'(DRAIN_CYCLES);
                end else if (state == DRAIN && !lu) begin
                    cnt_nxt   = cnt - 4'd1;
                    state_nxt = (cnt == 4'd1) ? HALTED : DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            cnt         <= 4'd0;
            halt        <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            halt  <= state_nxt == HALTED;
            if (stall_inc && !(&stall_count))
                stall_count <= stall_count + 1'b1;
            if (flush_inc && !(&flush_count))
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table through a scoreboard queue plus
// hand-written drain, abort, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0, rstn;
    logic halt_req_IF, rs1_used_Dec, rs2_used_Dec, wrEn_Exec, wrEn_Mem, wrEn_WB;
    logic is_load_Exec, is_load_Mem, npc_control_Mem;
    logic [4:0] rs1_Dec, rs2_Dec, rd_Exec, rd_Mem, rd_WB;
    logic stall_IF, stall_Dec, bubble_Exec, flush_IFDec, flush_DecExec, flush_ExecMem, halt;
    logic [1:0] fwd_A_sel, fwd_B_sel;
    logic [31:0] stall_count, flush_count;
    logic s_stall_IF, s_stall_Dec, s_bubble, s_f1, s_f2, s_f3, s_halt;
    logic [1:0] s_fa, s_fb;
    logic [3:0] s_stall_count, s_flush_count;
    int n_vec = 0, n_bad = 0;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rde, rdm, rdw;
        logic       we, wm, ww, le, lm, npc;
        logic [1:0] fa, fb;
        logic       si, sd, bu, fl;
    } vec_t;

    vec_t vt[12];
    vec_t sb[$];
    vec_t e;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .halt_req_IF(halt_req_IF),
        .rs1_Dec(rs1_Dec), .rs2_Dec(rs2_Dec), .rs1_used_Dec(rs1_used_Dec), .rs2_used_Dec(rs2_used_Dec),
        .rd_Exec(rd_Exec), .rd_Mem(rd_Mem), .rd_WB(rd_WB),
        .wrEn_Exec(wrEn_Exec), .wrEn_Mem(wrEn_Mem), .wrEn_WB(wrEn_WB),
        .is_load_Exec(is_load_Exec), .is_load_Mem(is_load_Mem), .npc_control_Mem(npc_control_Mem),
        .stall_IF(stall_IF), .stall_Dec(stall_Dec), .bubble_Exec(bubble_Exec),
        .flush_IFDec(flush_IFDec), .flush_DecExec(flush_DecExec), .flush_ExecMem(flush_ExecMem),
        .fwd_A_sel(fwd_A_sel), .fwd_B_sel(fwd_B_sel), .halt(halt),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .halt_req_IF(halt_req_IF),
        .rs1_Dec(rs1_Dec), .rs2_Dec(rs2_Dec), .rs1_used_Dec(rs1_used_Dec), .rs2_used_Dec(rs2_used_Dec),
        .rd_Exec(rd_Exec), .rd_Mem(rd_Mem), .rd_WB(rd_WB),
        .wrEn_Exec(wrEn_Exec), .wrEn_Mem(wrEn_Mem), .wrEn_WB(wrEn_WB),
        .is_load_Exec(is_load_Exec), .is_load_Mem(is_load_Mem), .npc_control_Mem(npc_control_Mem),
        .stall_IF(s_stall_IF), .stall_Dec(s_stall_Dec), .bubble_Exec(s_bubble),
        .flush_IFDec(s_f1), .flush_DecExec(s_f2), .flush_ExecMem(s_f3),
        .fwd_A_sel(s_fa), .fwd_B_sel(s_fb), .halt(s_halt),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear();
        halt_req_IF = 1'b0; npc_control_Mem = 1'b0;
        rs1_Dec = '0; rs2_Dec = '0; rs1_used_Dec = 1'b0; rs2_used_Dec = 1'b0;
        rd_Exec = '0; rd_Mem = '0; rd_WB = '0;
        wrEn_Exec = 1'b0; wrEn_Mem = 1'b0; wrEn_WB = 1'b0;
        is_load_Exec = 1'b0; is_load_Mem = 1'b0;
    endtask

    task automatic set_in(input vec_t v);
        rs1_Dec = v.rs1; rs2_Dec = v.rs2; rs1_used_Dec = v.u1; rs2_used_Dec = v.u2;
        rd_Exec = v.rde; rd_Mem = v.rdm; rd_WB = v.rdw;
        wrEn_Exec = v.we; wrEn_Mem = v.wm; wrEn_WB = v.ww;
        is_load_Exec = v.le; is_load_Mem = v.lm; npc_control_Mem = v.npc;
        halt_req_IF = 1'b0;
    endtask

    task automatic lu_exec();
        rs1_Dec = 5'd5; rs1_used_Dec = 1'b1; rd_Exec = 5'd5; wrEn_Exec = 1'b1; is_load_Exec = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            rs1   rs2   u1    u2    rde   rdm   rdw   we    wm    ww    le    lm    npc   fa     fb     si    sd    bu    fl
        vt[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

        // Combinational outputs must be held low while reset is asserted.
        rstn = 1'b0;
        clear();
        lu_exec();
        npc_control_Mem = 1'b1;
        #1;
        chk("rst stall_IF", 32'(stall_IF), 0);
        chk("rst bubble", 32'(bubble_Exec), 0);
        chk("rst flush_ExecMem", 32'(flush_ExecMem), 0);
        chk("rst halt", 32'(halt), 0);
        chk("rst stall_count", stall_count, 0);
        chk("rst flush_count", flush_count, 0);
        clear();
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(vt[i]);
            sb.push_back(vt[i]);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d fwd_A", i), 32'(fwd_A_sel), 32'(e.fa));
            chk($sformatf("v%0d fwd_B", i), 32'(fwd_B_sel), 32'(e.fb));
            chk($sformatf("v%0d stall_IF", i), 32'(stall_IF), 32'(e.si));
            chk($sformatf("v%0d stall_Dec", i), 32'(stall_Dec), 32'(e.sd));
            chk($sformatf("v%0d bubble", i), 32'(bubble_Exec), 32'(e.bu));
            chk($sformatf("v%0d flushes", i), 32'({flush_IFDec, flush_DecExec, flush_ExecMem}), 32'({3{e.fl}}));
        end

        // Load walks Exec -> Mem -> WB behind a dependent instruction.
        do_reset();
        @(negedge clk); clear(); lu_exec();
        #2 chk("lu exec stall", 32'({stall_IF, stall_Dec, bubble_Exec}), 32'b111);
        @(negedge clk); clear(); rs1_Dec = 5'd5; rs1_used_Dec = 1'b1; rd_Mem = 5'd5; wrEn_Mem = 1'b1; is_load_Mem = 1'b1;
        #2 chk("lu mem stall", 32'({stall_IF, stall_Dec, bubble_Exec}), 32'b111);
        @(negedge clk); clear(); rs1_Dec = 5'd5; rs1_used_Dec = 1'b1; rd_WB = 5'd5; wrEn_WB = 1'b1;
        #2 chk("lu wb stall", 32'({stall_IF, stall_Dec, bubble_Exec}), 32'b000);
        chk("lu wb fwd_A", 32'(fwd_A_sel), 32'(2'b10));
        chk("lu stall_count", stall_count, 2);

        // Redirect beats a simultaneous load-use hazard.
        @(negedge clk); clear(); lu_exec(); npc_control_Mem = 1'b1;
        #2 chk("redir flushes", 32'({flush_IFDec, flush_DecExec, flush_ExecMem}), 32'b111);
        chk("redir stalls", 32'({stall_IF, stall_Dec, bubble_Exec}), 32'b000);
        @(negedge clk); clear();
        #2 chk("redir flush_count", flush_count, 1);
        chk("redir stall_count", stall_count, 2);

        // Clean halt drain: halt rises 4 edges after the sampling edge.
        @(negedge clk); halt_req_IF = 1'b1;
        #2 chk("halt req stall_IF", 32'(stall_IF), 0);
        @(negedge clk); halt_req_IF = 1'b0;
        #2 chk("drain outs", 32'({stall_IF, flush_IFDec, flush_DecExec, halt}), 32'b1100);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #2 chk($sformatf("drain edge %0d halt", k), 32'(halt), 32'(k == 4));
        end
        lu_exec();
        #2 chk("halted outs", 32'({stall_IF, stall_Dec, flush_IFDec, flush_DecExec, flush_ExecMem}), 32'b11111);
        @(negedge clk);
        #2 chk("halted sticky", 32'(halt), 1);
        chk("halted stall_count frozen", stall_count, 2);
        rstn = 1'b0;
        #1 chk("rst halted halt", 32'(halt), 0);
        chk("rst halted stall_count", stall_count, 0);
        chk("rst halted flush_count", flush_count, 0);
        chk("rst halted stall_IF", 32'(stall_IF), 0);
        clear();
        @(negedge clk); rstn = 1'b1;

        // One load-use stall inside the drain delays halt by one edge.
        @(negedge clk); halt_req_IF = 1'b1;
        @(negedge clk); halt_req_IF = 1'b0; lu_exec();
        #2 chk("drain lu outs", 32'({stall_IF, stall_Dec, bubble_Exec}), 32'b111);
        @(negedge clk); clear();
        #2 chk("drain lu edge 1 halt", 32'(halt), 0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            #2 chk($sformatf("drain lu edge %0d halt", k), 32'(halt), 32'(k == 5));
        end
        do_reset();

        // Redirect at drain edge 2 aborts the halt.
        @(negedge clk); halt_req_IF = 1'b1;
        @(negedge clk); halt_req_IF = 1'b0;
        @(negedge clk); npc_control_Mem = 1'b1;
        #2 chk("abort flushes", 32'({flush_IFDec, flush_DecExec, flush_ExecMem, stall_IF}), 32'b1110);
        @(negedge clk); npc_control_Mem = 1'b0;
        #2 chk("abort run outs", 32'({stall_IF, flush_IFDec}), 32'b00);
        chk("abort flush_count", flush_count, 1);
        repeat (6) @(negedge clk);
        #2 chk("abort no halt", 32'(halt), 0);

        // Async reset in the middle of a drain.
        @(negedge clk); halt_req_IF = 1'b1;
        @(negedge clk); halt_req_IF = 1'b0;
        @(negedge clk);
        #2 chk("mid drain stall_IF", 32'(stall_IF), 1);
        rstn = 1'b0;
        #1 chk("rst drain stall_IF", 32'(stall_IF), 0);
        chk("rst drain flush_count", flush_count, 0);
        @(negedge clk); rstn = 1'b1;
        #2 chk("post rst run stall_IF", 32'(stall_IF), 0);
        repeat (6) @(negedge clk);
        #2 chk("post rst no halt", 32'(halt), 0);

        // Halt request on the wrong path is ignored.
        @(negedge clk); halt_req_IF = 1'b1; npc_control_Mem = 1'b1;
        @(negedge clk); clear();
        #2 chk("wrong path halt stall_IF", 32'(stall_IF), 0);
        repeat (6) @(negedge clk);
        #2 chk("wrong path no halt", 32'(halt), 0);

        // Counter saturation on the narrow instance.
        do_reset();
        @(negedge clk); lu_exec();
        repeat (20) @(negedge clk);
        #2 chk("sat stall_count", 32'(s_stall_count), 15);
        chk("wide stall_count", stall_count, 20);
        clear();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage IF/Dec/Exec/Mem/WB RISC-V pipeline.
- Detects load-use hazards (stall plus bubble) and produces operand forwarding selects for Exec.
- Squashes wrong-path instructions when Mem redirects the PC.
- Drains the pipeline on a fetched halt and then asserts a registered halt.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DRAIN_CYCLES, 4: active cycles after the halt is sampled before halt asserts (legal 1..15).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- halt_req_IF  in  1  halt instruction fetched this cycle
- rs1_Dec, rs2_Dec  in  5 each  source registers of the instruction in Dec
- rs1_used_Dec, rs2_used_Dec  in  1 each  instruction in Dec reads rs1 / rs2
- rd_Exec, rd_Mem, rd_WB  in  5 each  destination registers per stage
- wrEn_Exec, wrEn_Mem, wrEn_WB  in  1 each  register write enables per stage
- is_load_Exec, is_load_Mem  in  1 each  instruction is a load (wb_sel selects memory data)
- npc_control_Mem  in  1  taken branch or jump resolved in Mem
- stall_IF  out  1  hold the PC and the IF/Dec register
- stall_Dec  out  1  hold the Dec/Exec source operands
- bubble_Exec  out  1  load NOP/zero controls into Dec→Exec
- flush_IFDec, flush_DecExec, flush_ExecMem  out  1 each  zero the controls of that pipeline register
- fwd_A_sel, fwd_B_sel  out  2 each  00 = register file, 01 = Mem ALU result, 10 = WB write data
- halt  out  1  pipeline drained and halted (registered)
- stall_count, flush_count  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rstn low, asynchronous):
  - state = RUN; drain counter = 0; halt = 0; both counters = 0.
  - All combinational outputs are forced to 0 while rstn is low.
- Forwarding (combinational, per operand X in {A: rs1, B: rs2}):
  - 01 when wrEn_Mem, !is_load_Mem, rd_Mem != 0 and rd_Mem == rsX_Dec.
  - Otherwise 10 when wrEn_WB, rd_WB != 0 and rd_WB == rsX_Dec.
  - Otherwise 00.
  - Mem has priority over WB. x0 is never forwarded.
- Load-use hazard (lu), combinational:
  - Condition: a used rsX equals a nonzero rd of a writing load in Exec, or of a writing load in Mem.
  - Effect: stall_IF = stall_Dec = bubble_Exec = 1.
  - A load immediately ahead therefore costs 2 cycles and a load two ahead costs 1, because load data forwards only from WB.
- Redirect (npc_control_Mem = 1):
  - flush_IFDec = flush_DecExec = flush_ExecMem = 1.
  - stall_IF, stall_Dec and bubble_Exec are forced to 0; redirect beats lu in the same cycle.
- State machine (states RUN, DRAIN, HALTED):
  - RUN: halt_req_IF = 1 with no redirect → DRAIN, counter <= DRAIN_CYCLES.
  - RUN: a simultaneous redirect wins and the halt request is ignored (wrong path).
  - DRAIN outputs: stall_IF = 1 and flush_IFDec = 1 (fetch frozen, bubbles fed into Dec).
  - DRAIN counting: the counter decrements only on cycles with stall_Dec = 0, so a load-use stall pauses the drain.
  - DRAIN → HALTED on the edge where the counter == 1 and is decrementing; halt <= 1.
  - DRAIN abort: npc_control_Mem = 1 → RUN, counter <= 0, normal flush outputs. The halt was on the wrong path.
  - HALTED: sticky until reset. stall_IF = stall_Dec = 1, all flushes = 1, counters frozen.
  - Net latency with no stalls: halt rises exactly DRAIN_CYCLES edges after the edge that sampled halt_req_IF.
- Counters:
  - stall_count increments on each cycle with lu = 1 and no redirect, in RUN or DRAIN.
  - flush_count increments on each cycle with npc_control_Mem = 1, in RUN or DRAIN.
  - Both saturate at all-ones.
- Reset mid-DRAIN or in HALTED returns immediately to the RUN reset values.

Test Plan:
- lw x5 in Exec (rd_Exec = 5, is_load_Exec = 1, wrEn_Exec = 1); Dec reads rs1 = 5 → stall_IF/stall_Dec/bubble_Exec = 1. Next cycle the load is in Mem → still 1. Following cycle → 0 and fwd_A_sel = 10. stall_count = 2.
- add x3 in Mem (wrEn_Mem = 1, rd_Mem = 3) and add x3 in WB; Dec reads rs2 = 3 → fwd_B_sel = 01. Same with rd = 0 → fwd_B_sel = 00, no stall.
- npc_control_Mem = 1 while the lu condition is also true → three flushes = 1, stall_IF = 0, bubble_Exec = 0. flush_count increments by 1 and stall_count is unchanged.
- halt_req_IF pulse with DRAIN_CYCLES = 4 and no stalls → stall_IF = 1 from the next cycle; halt = 1 exactly 4 edges after sampling, and it stays 1 with halt_req_IF = 0.
- Halt drain with a 1-cycle lu stall inside DRAIN → halt rises at 5 edges. Separate run: npc_control_Mem at drain edge 2 → state RUN, halt stays 0, stall_IF = 0.
- Assert rstn = 0 mid-DRAIN and in HALTED → halt = 0, counters = 0 asynchronously. With CNT_W = 4, force 20 lu cycles → stall_count holds at 15.
